mul_issue_queue: RTL and testbench
==================================

Name: mul_issue_queue

Overview:
- Upstream operand stage for multiplier_iterative.
- Buffers 32-bit operand pairs in a small FIFO and issues them one at a time to the iterative multiplier using its single-cycle valid_in pulse.
- Waits for the multiplier's valid_out, then captures the 64-bit product into a ready/valid output register for the consumer.
- Hides the multiplier's variable latency from producers and consumers.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, at least 2.
- WIDTH, 32, operand width; product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  producer has an operand pair
- in_ready  output  1  FIFO can accept; equals !full
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- mul_valid_in  output  1  one-cycle start pulse to the multiplier
- mul_a  output  WIDTH  operand a to the multiplier; held stable from issue until the result arrives
- mul_b  output  WIDTH  operand b to the multiplier; held stable from issue until the result arrives
- mul_valid_out  input  1  multiplier result strobe; mul_r is valid in that cycle only
- mul_r  input  2*WIDTH  multiplier product
- out_valid  output  1  out_r holds an unconsumed product
- out_ready  input  1  consumer accepts the product
- out_r  output  2*WIDTH  product register
- level  output  $clog2(DEPTH)+1  FIFO occupancy
- spurious_err  output  1  sticky error flag

Behaviour:
- Reset (synchronous, highest priority, any state):
  - FIFO emptied, level=0, in_ready=1.
  - FSM goes to IDLE.
  - mul_valid_in=0, mul_a=0, mul_b=0.
  - out_valid=0, out_r=0, spurious_err=0.
  - Any product in flight is discarded.
- FIFO:
  - Push when in_valid && in_ready; data is in_a/in_b.
  - full and empty are registered state, taken from level at the start of the cycle.
  - in_ready is low when full, even if a pop occurs in the same cycle (no push-through when full).
  - A pop requires level>0 at the start of the cycle; a pair pushed this cycle cannot be popped this cycle.
  - Simultaneous push and pop leaves level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - If the FIFO is non-empty: pop the head into mul_a/mul_b, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - mul_valid_in=1 for exactly this one cycle; go to WAIT.
  - mul_valid_out seen in this cycle sets spurious_err and is otherwise ignored.
- WAIT:
  - mul_valid_in=0; mul_a/mul_b held.
  - On mul_valid_out: out_r<=mul_r, out_valid<=1, go to HOLD.
- HOLD:
  - out_valid=1; out_r is stable until consumed.
  - If out_ready and the FIFO is non-empty: pop into mul_a/mul_b, go to ISSUE. out_valid falls in the next cycle.
  - If out_ready and the FIFO is empty: out_valid<=0, go to IDLE.
  - If !out_ready: stay in HOLD. No new issue occurs (single product register, no overwrite).
- mul_valid_out in IDLE or HOLD is ignored and not flagged. This covers stragglers from a multiplier still running after reset.
- Latency, empty queue, FSM in IDLE:
  - Pair accepted at edge E.
  - Popped at edge E+1.
  - mul_valid_in high in the cycle after edge E+1.
  - out_valid rises at the edge after mul_valid_out is seen.
- Throughput: one product per (multiplier latency + 2) cycles when the consumer is always ready.
- Products leave in push order; there is no reordering or dropping.
- Widths: the product is passed through unmodified at 2*WIDTH bits. No truncation or sign handling (unsigned multiplier).

Test Plan:
- Single op: push a=3, b=5; behavioural multiplier with latency 7 -> exactly one mul_valid_in pulse with mul_a=3, mul_b=5 held until valid_out; out_r=15, out_valid=1 until out_ready.
- Fill: push DEPTH+1=5 pairs back-to-back with out_ready=0 -> level reaches 4, in_ready drops, first product held in HOLD, no second issue; then out_ready=1 -> all products drain in push order, level returns to 0.
- Corner values: a=b=32'hFFFFFFFF -> out_r=64'hFFFFFFFE00000001; a=0, b=32'h12345678 -> out_r=0.
- Random: 200 pairs, consumer ready randomized at 50%, a stepped by 32'h23456789, b stepped by 32'h34567891 -> every out_r equals a*b in order; mul_valid_in is never asserted outside ISSUE.
- Reset mid-WAIT with 2 pairs queued -> next cycle level=0, out_valid=0, FSM IDLE; a late mul_valid_out is ignored and spurious_err stays 0.
- Spurious strobe: drive mul_valid_out in the ISSUE cycle -> spurious_err=1 and stays 1 until reset; no product captured from that strobe.

Source files
------------

// File: rtl/mul_issue_queue.sv
// mul_issue_queue
//
// Operand queue in front of an iterative multiplier. Operand pairs are
// buffered in a small FIFO. They are issued one at a time with a single-cycle
// start pulse, and the operands are held stable until the multiplier strobes
// its result. The product is then parked in a ready/valid output register
// until the consumer takes it. The multiplier's variable latency is hidden
// from both the producer and the consumer.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   in_valid/in_ready, in_a/in_b        producer side (in_ready = !full)
//   mul_valid_in, mul_a, mul_b           start pulse and operands to multiplier
//   mul_valid_out, mul_r                 result strobe and product from multiplier
//   out_valid/out_ready, out_r           consumer side product register
//   level                                FIFO occupancy
//   spurious_err                         sticky: result strobe seen in the issue cycle
module mul_issue_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  output logic                       mul_valid_in,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic                       mul_valid_out,
  input  logic [2*WIDTH-1:0]         mul_r,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*WIDTH-1:0]         out_r,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       spurious_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // full/empty come from the registered level only, so a pop in the same
  // cycle never opens a slot for a push (no push-through when full).
  assign full     = (level_reg == FULL_LEVEL);
  assign empty    = (level_reg == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign level    = level_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_reg] <= in_a;
      mem_b[wr_ptr_reg] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t state_reg;
  state_t state_next;
  logic   capture;
  logic   release_out;
  logic   spur_set;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    pop         = 1'b0;
    capture     = 1'b0;
    release_out = 1'b0;
    spur_set    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The multiplier cannot answer in the cycle it is started.
        if (mul_valid_out) spur_set = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (mul_valid_out) begin
          capture    = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Single product register: only issue again once it is consumed.
        if (out_ready) begin
          release_out = 1'b1;
          if (!empty) begin
            pop        = 1'b1;
            state_next = ST_ISSUE;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign mul_valid_in = (state_reg == ST_ISSUE);

  // ---------------------------------------------------------------- datapath
  logic [WIDTH-1:0]   mul_a_reg;
  logic [WIDTH-1:0]   mul_b_reg;
  logic [2*WIDTH-1:0] out_r_reg;
  logic               out_valid_reg;
  logic               spur_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_a_reg     <= '0;
      mul_b_reg     <= '0;
      out_r_reg     <= '0;
      out_valid_reg <= 1'b0;
      spur_reg      <= 1'b0;
    end else begin
      // Operands are loaded only on a pop, so they stay stable through
      // the issue and wait phases.
      if (pop) begin
        mul_a_reg <= mem_a[rd_ptr_reg];
        mul_b_reg <= mem_b[rd_ptr_reg];
      end
      if (capture) begin
        out_r_reg     <= mul_r;
        out_valid_reg <= 1'b1;
      end else if (release_out) begin
        out_valid_reg <= 1'b0;
      end
      if (spur_set) spur_reg <= 1'b1;
    end
  end

  assign mul_a        = mul_a_reg;
  assign mul_b        = mul_b_reg;
  assign out_r        = out_r_reg;
  assign out_valid    = out_valid_reg;
  assign spurious_err = spur_reg;

endmodule

// File: tb/tb_mul_issue_queue.sv
// Bench for mul_issue_queue: behavioural multiplier, a queue-based reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_mul_issue_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a = '0;
  logic [WIDTH-1:0]  in_b = '0;
  logic              mul_valid_in;
  logic [WIDTH-1:0]  mul_a;
  logic [WIDTH-1:0]  mul_b;
  logic              mul_valid_out = 1'b0;
  logic [63:0]       mul_r = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [63:0]       out_r;
  logic [2:0]        level;
  logic              spurious_err;

  mul_issue_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_valid_in(mul_valid_in), .mul_a(mul_a), .mul_b(mul_b),
    .mul_valid_out(mul_valid_out), .mul_r(mul_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .level(level), .spurious_err(spurious_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int consumed = 0;
  int iss_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------- behavioural multiplier
  int          lat = 7;
  bit          rand_lat = 1'b0;
  bit          inj_strobe = 1'b0;
  int          cnt = 0;
  logic [63:0] ma = '0;
  logic [63:0] mb = '0;

  initial begin
    forever begin
      @(negedge clk);
      mul_valid_out = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mul_valid_out = 1'b1;
          mul_r = ma * mb;
        end
      end
      if (mul_valid_in) begin
        iss_cnt++;
        ma = 64'(mul_a);
        mb = 64'(mul_b);
        cnt = rand_lat ? int'($urandom_range(1, 8)) : lat;
        if (inj_strobe) begin
          mul_valid_out = 1'b1;
          mul_r = 64'hBAD0BAD0BAD0BAD0;
          inj_strobe = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------- reference model
  logic [63:0] mq[$];        // pairs {a,b} waiting in the FIFO
  logic [63:0] order_q[$];   // products in push order, not yet consumed
  bit          m_issue = 0, m_busy = 0, m_have = 0, m_spur = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [63:0] m_out = '0;

  initial begin
    logic [63:0] p;
    bit          do_pop;
    bit          do_push;
    forever begin
      @(negedge clk);
      #1;
      if (chk_en) begin
        chk("level", 64'(level), 64'(mq.size()));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        chk("mul_valid_in", 64'(mul_valid_in), 64'(m_issue));
        if (m_issue || m_busy) begin
          chk("mul_a_held", 64'(mul_a), 64'(m_a));
          chk("mul_b_held", 64'(mul_b), 64'(m_b));
        end
        chk("out_valid", 64'(out_valid), 64'(m_have));
        if (m_have) chk("out_r_stable", out_r, m_out);
        chk("spurious_err", 64'(spurious_err), 64'(m_spur));
      end
      if (reset) begin
        mq.delete();
        order_q.delete();
        m_issue = 0; m_busy = 0; m_have = 0; m_spur = 0;
        m_a = '0; m_b = '0; m_out = '0;
      end else begin
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = 1'b0;
        if (m_issue) begin
          if (mul_valid_out) m_spur = 1;
          m_issue = 0;
          m_busy  = 1;
        end else if (m_busy) begin
          if (mul_valid_out) begin
            m_have = 1;
            m_out  = mul_r;
            m_busy = 0;
          end
        end else if (m_have) begin
          if (out_ready) begin
            if (order_q.size() == 0) begin
              chk("consume_unexpected", out_r, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
              p = order_q.pop_front();
              chk("product_order", out_r, p);
              $display("consume #%0d out_r=%h", consumed, out_r);
            end
            consumed++;
            m_have = 0;
            do_pop = 1'b1;
          end
        end else begin
          do_pop = 1'b1;
        end
        if (do_pop && mq.size() > 0) begin
          p = mq.pop_front();
          m_a = p[63:32];
          m_b = p[31:0];
          m_issue = 1;
        end
        if (do_push) begin
          mq.push_back({in_a, in_b});
          order_q.push_back(64'(in_a) * 64'(in_b));
        end
      end
    end
  end

  // ---------------------------------------------------- stimulus helpers
  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("push_timeout", 64'(n), 64'(0));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!mul_valid_in && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("issue_timeout", 64'(n), 64'(0));
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("out_timeout", 64'(n), 64'(0));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------- scenarios
  initial begin
    int c0;
    int n;
    bit done;
    logic [31:0] a;
    logic [31:0] b;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_r", out_r, 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_valid_in", 64'(mul_valid_in), 64'd0);
    chk("rst_spur", 64'(spurious_err), 64'd0);

    // Single op, latency 7
    c0 = iss_cnt;
    push(32'd3, 32'd5);
    wait_issue();
    chk("single_mul_a", 64'(mul_a), 64'd3);
    chk("single_mul_b", 64'(mul_b), 64'd5);
    wait_out();
    chk("single_out_r", out_r, 64'd15);
    idle(4);
    chk("single_hold_valid", 64'(out_valid), 64'd1);
    chk("single_one_pulse", 64'(iss_cnt - c0), 64'd1);
    consume();
    chk("single_out_dropped", 64'(out_valid), 64'd0);

    // Corner values
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_out();
    chk("corner_max", out_r, 64'hFFFF_FFFE_0000_0001);
    consume();
    push(32'd0, 32'h1234_5678);
    wait_out();
    chk("corner_zero", out_r, 64'd0);
    consume();

    // Fill with consumer stalled
    c0 = iss_cnt;
    for (int i = 0; i < DEPTH + 1; i++) push(32'(2*i + 1), 32'(2*i + 2));
    idle(15);
    chk("fill_level", 64'(level), 64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_hold_out", out_r, 64'd2);
    chk("fill_no_second_issue", 64'(iss_cnt - c0), 64'd1);
    c0 = consumed;
    out_ready = 1'b1;
    idle(80);
    out_ready = 1'b0;
    chk("fill_drained", 64'(consumed - c0), 64'd5);
    chk("fill_level_zero", 64'(level), 64'd0);

    // Random consumer, 200 pairs, random multiplier latency
    rand_lat = 1'b1;
    c0 = consumed;
    done = 1'b0;
    fork
      begin
        a = 32'h0;
        b = 32'h0;
        for (int i = 0; i < 200; i++) begin
          a = a + 32'h2345_6789;
          b = b + 32'h3456_7891;
          push(a, b);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    out_ready = 1'b1;
    n = 0;
    while ((order_q.size() != 0 || out_valid) && n < 600) begin
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    chk("random_count", 64'(consumed - c0), 64'd200);
    rand_lat = 1'b0;
    idle(12);

    // Reset while waiting with two pairs queued
    lat = 7;
    push(32'd10, 32'd11);
    push(32'd12, 32'd13);
    push(32'd14, 32'd15);
    idle(1);
    chk("rstw_level_before", 64'(level), 64'd2);
    do_reset();
    chk("rstw_level", 64'(level), 64'd0);
    chk("rstw_out_valid", 64'(out_valid), 64'd0);
    chk("rstw_mul_a", 64'(mul_a), 64'd0);
    idle(12);
    chk("rstw_late_ignored", 64'(out_valid), 64'd0);
    chk("rstw_no_spur", 64'(spurious_err), 64'd0);

    // Spurious strobe in the issue cycle
    inj_strobe = 1'b1;
    push(32'd9, 32'd9);
    wait_out();
    chk("spur_set", 64'(spurious_err), 64'd1);
    chk("spur_real_product", out_r, 64'd81);
    consume();
    idle(5);
    chk("spur_sticky", 64'(spurious_err), 64'd1);
    do_reset();
    chk("spur_cleared", 64'(spurious_err), 64'd0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
